// File: rtl/neg_edge_bounded_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neg_edge_bounded_counter_pkg
// Description : Direction and boundary-mode encodings shared by the bounded
//               counter and the iteration-control FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package neg_edge_bounded_counter_pkg;

    // Direction encoding as presented on the 'down' input.
    localparam logic c_dir_up   = 1'b0;
    localparam logic c_dir_down = 1'b1;

    // Boundary behaviour selected by the SATURATE parameter.
    localparam int c_mode_wrap     = 0;
    localparam int c_mode_saturate = 1;

endpackage : neg_edge_bounded_counter_pkg
`default_nettype wire

// File: rtl/neg_edge_bounded_counter_reg.sv
`default_nettype none
// ============================================================================
// Module      : neg_edge_reg
// Description : WORD_SIZE-wide falling-edge register with asynchronous,
//               active-high reset to a programmable value.
// Revision    : 1.0 - initial release
// ============================================================================
module neg_edge_reg #(
    parameter int                    WORD_SIZE   = 32,
    parameter logic [WORD_SIZE-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  i_d,
    output logic [WORD_SIZE-1:0]  o_q
);

    logic [WORD_SIZE-1:0] r_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : neg_edge_reg
`default_nettype wire

// File: rtl/neg_edge_bounded_counter.sv
`default_nettype none
// ============================================================================
// Module      : neg_edge_bounded_counter
// Description : Falling-edge load/count counter with runtime direction and
//               step, inclusive upper bound, wrap or saturate at the bound and
//               a registered one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module neg_edge_bounded_counter
    import neg_edge_bounded_counter_pkg::*;
#(
    parameter int                    WORD_SIZE   = 32,
    parameter int                    SATURATE    = 0,
    parameter logic [WORD_SIZE-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [WORD_SIZE-1:0]  load_data,
    input  logic                  down,
    input  logic [WORD_SIZE-1:0]  limit,
    input  logic [WORD_SIZE-1:0]  step,
    output logic [WORD_SIZE-1:0]  count,
    output logic                  tc,
    output logic                  at_bound
);

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    logic [WORD_SIZE:0]    w_sum;
    logic                  w_up_over;
    logic [WORD_SIZE-1:0]  w_diff;
    logic                  w_dn_under;
    logic                  w_land_up;
    logic                  w_land_dn;

    // One extra bit keeps all-ones + step from aliasing back below limit.
    assign w_sum      = {1'b0, count} + {1'b0, step};
    assign w_up_over  = (w_sum > {1'b0, limit});
    assign w_diff     = count - step;
    assign w_dn_under = (count < step);

    // Arrival on the bound from a value that was not already the bound.
    assign w_land_up  = (w_sum[WORD_SIZE-1:0] == limit) && (count != limit);
    assign w_land_dn  = (w_diff == '0) && (count != '0);

    // ------------------------------------------------------------------
    // Boundary-mode specific out-of-range behaviour
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0]  w_up_over_count;
    logic                  w_up_over_tc;
    logic [WORD_SIZE-1:0]  w_dn_under_count;
    logic                  w_dn_under_tc;
    logic                  w_land_tc_en;

    generate
        if (SATURATE == c_mode_saturate) begin : g_saturate
            assign w_up_over_count  = limit;
            assign w_up_over_tc     = (count != limit);
            assign w_dn_under_count = '0;
            assign w_dn_under_tc    = (count != '0);
            assign w_land_tc_en     = 1'b1;
        end else begin : g_wrap
            assign w_up_over_count  = '0;
            assign w_up_over_tc     = 1'b1;
            assign w_dn_under_count = limit;
            assign w_dn_under_tc    = 1'b1;
            assign w_land_tc_en     = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state selection: load > enable > hold
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0]  w_count_next;
    logic                  w_tc_next;

    always_comb begin
        w_count_next = count;
        w_tc_next    = 1'b0;
        if (load) begin
            w_count_next = load_data;
        end else if (enable) begin
            if (down == c_dir_up) begin
                if (w_up_over) begin
                    w_count_next = w_up_over_count;
                    w_tc_next    = w_up_over_tc;
                end else begin
                    w_count_next = w_sum[WORD_SIZE-1:0];
                    w_tc_next    = w_land_tc_en & w_land_up;
                end
            end else begin
                if (w_dn_under) begin
                    w_count_next = w_dn_under_count;
                    w_tc_next    = w_dn_under_tc;
                end else begin
                    w_count_next = w_diff;
                    w_tc_next    = w_land_tc_en & w_land_dn;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    neg_edge_reg #(
        .WORD_SIZE   (WORD_SIZE),
        .RESET_VALUE (RESET_VALUE)
    ) u_count_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_count_next),
        .o_q (count)
    );

    neg_edge_reg #(
        .WORD_SIZE   (1),
        .RESET_VALUE (1'b0)
    ) u_tc_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_tc_next),
        .o_q (tc)
    );

    assign at_bound = (down == c_dir_down) ? (count == '0) : (count == limit);

endmodule : neg_edge_bounded_counter
`default_nettype wire

// File: tb/tb_neg_edge_bounded_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_neg_edge_bounded_counter
// Description : Self-checking bench; a wrap-mode and a saturate-mode counter
//               share stimulus and are compared against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neg_edge_bounded_counter;

    localparam int c_w = 8;

    logic              clk;
    logic              rst;
    logic              r_enable;
    logic              r_load;
    logic [c_w-1:0]    r_load_data;
    logic              r_down;
    logic [c_w-1:0]    r_limit;
    logic [c_w-1:0]    r_step;

    logic [c_w-1:0]    w_count [2];
    logic              w_tc    [2];
    logic              w_at_bound [2];

    int unsigned       m_cnt [2];
    bit                m_tc  [2];
    int unsigned       c_rv  [2] = '{0, 7};

    int                n_checks = 0;
    int                n_fail   = 0;

    neg_edge_bounded_counter #(
        .WORD_SIZE (c_w), .SATURATE (0), .RESET_VALUE (8'd0)
    ) u_dut_wrap (
        .clk (clk), .rst (rst), .enable (r_enable), .load (r_load),
        .load_data (r_load_data), .down (r_down), .limit (r_limit),
        .step (r_step), .count (w_count[0]), .tc (w_tc[0]),
        .at_bound (w_at_bound[0])
    );

    neg_edge_bounded_counter #(
        .WORD_SIZE (c_w), .SATURATE (1), .RESET_VALUE (8'd7)
    ) u_dut_sat (
        .clk (clk), .rst (rst), .enable (r_enable), .load (r_load),
        .load_data (r_load_data), .down (r_down), .limit (r_limit),
        .step (r_step), .count (w_count[1]), .tc (w_tc[1]),
        .at_bound (w_at_bound[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: one falling edge of an ideal bounded counter.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int unsigned c;
            int unsigned s;
            bit          sat;
            bit          t;
            c   = m_cnt[i];
            sat = (i == 1);
            t   = 1'b0;
            if (r_load) begin
                c = r_load_data;
            end else if (r_enable && !r_down) begin
                s = c + r_step;
                if (s <= r_limit) begin
                    t = sat && (s == r_limit) && (c != r_limit);
                    c = s;
                end else if (sat) begin
                    t = (c != r_limit);
                    c = r_limit;
                end else begin
                    t = 1'b1;
                    c = 0;
                end
            end else if (r_enable) begin
                if (c >= r_step) begin
                    t = sat && (c == r_step) && (c != 0);
                    c = c - r_step;
                end else if (sat) begin
                    t = (c != 0);
                    c = 0;
                end else begin
                    t = 1'b1;
                    c = r_limit;
                end
            end
            m_cnt[i] = c;
            m_tc[i]  = t;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit ab;
            ab = r_down ? (m_cnt[i] == 0) : (m_cnt[i] == r_limit);
            check_eq($sformatf("count[%0d]", i), w_count[i], m_cnt[i]);
            check_eq($sformatf("tc[%0d]", i), w_tc[i], m_tc[i]);
            check_eq($sformatf("at_bound[%0d]", i), w_at_bound[i], ab);
        end
    endtask

    task automatic drive_cycle(input bit en, input bit ld, input bit dn,
                               input int unsigned ldd, input int unsigned lim,
                               input int unsigned stp);
        @(posedge clk);
        r_enable    = en;
        r_load      = ld;
        r_down      = dn;
        r_load_data = ldd[c_w-1:0];
        r_limit     = lim[c_w-1:0];
        r_step      = stp[c_w-1:0];
        @(negedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Called 1 time unit after a falling edge; pulse stays clear of the next edges.
    task automatic async_reset_pulse();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = c_rv[i];
            m_tc[i]  = 1'b0;
        end
        check_eq("async_rst_count0", w_count[0], c_rv[0]);
        check_eq("async_rst_count1", w_count[1], c_rv[1]);
        check_eq("async_rst_tc0", w_tc[0], 0);
        check_eq("async_rst_tc1", w_tc[1], 0);
        rst = 1'b0;
    endtask

    int unsigned seq_up_w [4] = '{2, 4, 0, 2};
    int unsigned seq_up_s [4] = '{2, 4, 5, 5};
    int unsigned seq_dn_w [3] = '{1, 9, 7};
    int unsigned seq_dn_s [3] = '{1, 0, 0};

    initial begin
        rst = 1'b1; r_enable = 1'b0; r_load = 1'b0; r_load_data = '0;
        r_down = 1'b0; r_limit = '0; r_step = '0;
        m_cnt[0] = c_rv[0]; m_cnt[1] = c_rv[1]; m_tc[0] = 1'b0; m_tc[1] = 1'b0;
        #3;
        check_eq("reset_count0", w_count[0], 0);
        check_eq("reset_count1", w_count[1], 7);
        check_eq("reset_tc0", w_tc[0], 0);
        check_eq("reset_tc1", w_tc[1], 0);
        #4 rst = 1'b0;

        // Up count, limit 5, step 2
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 5, 2);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 0, 5, 2);
            check_eq("up_wrap_seq", w_count[0], seq_up_w[k]);
            check_eq("up_sat_seq", w_count[1], seq_up_s[k]);
            check_eq("up_wrap_tc", w_tc[0], (k == 2) ? 1 : 0);
            check_eq("up_sat_tc", w_tc[1], (k == 2) ? 1 : 0);
        end
        check_eq("up_sat_at_bound", w_at_bound[1], 1);

        // Down count from 3, limit 9, step 2
        drive_cycle(1'b0, 1'b1, 1'b1, 3, 9, 2);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 0, 9, 2);
            check_eq("dn_wrap_seq", w_count[0], seq_dn_w[k]);
            check_eq("dn_sat_seq", w_count[1], seq_dn_s[k]);
            check_eq("dn_wrap_tc", w_tc[0], (k == 1) ? 1 : 0);
            check_eq("dn_sat_tc", w_tc[1], (k == 1) ? 1 : 0);
        end

        // Full-scale aliasing and load above limit with step 0
        drive_cycle(1'b0, 1'b1, 1'b0, 255, 255, 1);
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 255, 1);
        check_eq("fullscale_wrap_count", w_count[0], 0);
        check_eq("fullscale_wrap_tc", w_tc[0], 1);
        drive_cycle(1'b0, 1'b1, 1'b0, 200, 100, 0);
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 100, 0);
        check_eq("over_limit_wrap_count", w_count[0], 0);
        check_eq("over_limit_sat_count", w_count[1], 100);
        check_eq("over_limit_sat_tc", w_tc[1], 1);

        // Load wins over enable, then hold
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h3C, 255, 1);
        check_eq("load_prio_count", w_count[0], 8'h3C);
        check_eq("load_prio_tc", w_tc[0], 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 255, 1);
        check_eq("hold_count", w_count[1], 8'h3C);

        // Asynchronous reset mid-cycle from count 4
        drive_cycle(1'b0, 1'b1, 1'b0, 4, 9, 1);
        async_reset_pulse();
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 9, 1);
        check_eq("resume_sat_count", w_count[1], 8);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int unsigned lim;
            int unsigned stp;
            bit          dn;
            lim = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                              : $urandom_range(0, 12);
            stp = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                               : $urandom_range(0, 4);
            dn  = ($urandom_range(0, 4) == 0) ? ~r_down : r_down;
            drive_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 11) == 0,
                        dn, $urandom_range(0, 255), lim, stp);
            if ($urandom_range(0, 49) == 0) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_neg_edge_bounded_counter
`default_nettype wire
